// File: rtl/a25_mem_wb_pkg.sv
// Shared types and constants for the a25 data-memory / load-return stage.
package a25_mem_wb_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BE_W     = 4;
    localparam int unsigned LRD_W    = 9;
    localparam int unsigned WB_RD_W  = 11;
    localparam int unsigned CNT_W    = 16;

    // Load size encodings carried in the descriptor; 2'b11 also means word
    localparam logic [1:0] LD_WORD = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_BYTE = 2'b10;

    // Load descriptor field positions
    localparam int unsigned LRD_REG_LSB  = 0;
    localparam int unsigned LRD_USER     = 4;
    localparam int unsigned LRD_SIZE_LSB = 5;
    localparam int unsigned LRD_SIGN     = 7;
    localparam int unsigned LRD_PASS     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WB   = 2'b10
    } mem_wb_state_t;

endpackage

// File: rtl/a25_load_align.sv
// Load data alignment: ARM-style rotation for words, lane select plus
// zero/sign extension for halfwords and bytes.
module a25_load_align
    import a25_mem_wb_pkg::*;
(
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_off,
    input  logic [1:0]        i_size,
    input  logic              i_sign,
    output logic [DATA_W-1:0] o_result_c
);

    logic [DATA_W-1:0] w_rot;
    logic [15:0]       w_half;
    logic [7:0]        w_byte;

    // Select lane / rotate according to byte offset, then extend by size
    always_comb begin
        w_rot      = i_rdata;
        w_half     = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        w_byte     = i_rdata[{i_off, 3'b000} +: 8];
        o_result_c = i_rdata;

        case (i_off)
            2'd1:    w_rot = {i_rdata[7:0],  i_rdata[31:8]};
            2'd2:    w_rot = {i_rdata[15:0], i_rdata[31:16]};
            2'd3:    w_rot = {i_rdata[23:0], i_rdata[31:24]};
            default: w_rot = i_rdata;
        endcase

        case (i_size)
            LD_HALF: o_result_c = {{16{i_sign & w_half[15]}}, w_half};
            LD_BYTE: o_result_c = {{24{i_sign & w_byte[7]}},  w_byte};
            default: o_result_c = w_rot;
        endcase
    end

endmodule

// File: rtl/a25_mem_wb.sv
// Data-memory access and load write-back stage downstream of a25_execute.
// One access in flight at a time over a req/ack port, with bus-error and
// timeout abort, and aligned load data returned on the write-back outputs.
module a25_mem_wb
    import a25_mem_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_core_stall,
    input  logic [DATA_W-1:0]   i_daddress,
    input  logic                i_daddress_valid,
    input  logic                i_write_enable,
    input  logic [DATA_W-1:0]   i_write_data,
    input  logic [BE_W-1:0]     i_byte_enable,
    input  logic [LRD_W-1:0]    i_exec_load_rd,
    output logic                o_mem_stall,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [DATA_W-1:0]   o_mem_addr,
    output logic [BE_W-1:0]     o_mem_be,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic                i_mem_ack,
    input  logic                i_mem_err,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic [DATA_W-1:0]   o_wb_read_data,
    output logic                o_wb_read_data_valid,
    output logic [WB_RD_W-1:0]  o_wb_load_rd,
    output logic                o_dabort
);

    localparam int unsigned CNT_INC_W = CNT_W + 1;

    mem_wb_state_t        r_state;
    logic [DATA_W-1:0]    r_addr;
    logic                 r_we;
    logic [BE_W-1:0]      r_be;
    logic [DATA_W-1:0]    r_wdata;
    logic [LRD_W-1:0]     r_lrd;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_mem_req;
    logic                 r_mem_stall;
    logic                 r_dabort;
    logic                 r_wb_valid;
    logic [DATA_W-1:0]    r_wb_data;
    logic [WB_RD_W-1:0]   r_wb_load_rd;

    logic                 w_accept;
    logic [CNT_INC_W-1:0] w_cnt_inc;
    logic                 w_timeout;
    logic [DATA_W-1:0]    w_align;

    assign w_accept  = i_daddress_valid && !i_core_stall;
    assign w_cnt_inc = {1'b0, r_cnt} + CNT_INC_W'(1);
    assign w_timeout = (w_cnt_inc == CNT_INC_W'(TIMEOUT_CYCLES));

    a25_load_align u_align (
        .i_rdata    (i_mem_rdata),
        .i_off      (r_addr[1:0]),
        .i_size     (r_lrd[LRD_SIZE_LSB +: 2]),
        .i_sign     (r_lrd[LRD_SIGN]),
        .o_result_c (w_align)
    );

    // Access FSM with all port and write-back outputs registered
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_lrd        <= '0;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_stall  <= 1'b0;
            r_dabort     <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_wb_data    <= '0;
            r_wb_load_rd <= '0;
        end else begin
            r_dabort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= i_daddress;
                        r_we        <= i_write_enable;
                        r_be        <= i_write_enable ? i_byte_enable : 4'hF;
                        r_wdata     <= i_write_data;
                        r_lrd       <= i_exec_load_rd;
                        r_cnt       <= '0;
                        r_mem_req   <= 1'b1;
                        r_mem_stall <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_mem_ack) begin
                        // An ack always beats a timeout reached in the same cycle
                        r_mem_req <= 1'b0;
                        if (i_mem_err) begin
                            r_dabort    <= 1'b1;
                            r_mem_stall <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else if (r_we) begin
                            r_mem_stall <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_wb_data    <= w_align;
                            r_wb_load_rd <= {r_addr[1:0], r_lrd};
                            r_wb_valid   <= 1'b1;
                            r_mem_stall  <= i_core_stall;
                            r_state      <= ST_WB;
                        end
                    end else if (w_timeout) begin
                        r_mem_req   <= 1'b0;
                        r_dabort    <= 1'b1;
                        r_mem_stall <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                    end
                end
                ST_WB: begin
                    // Result held until the core is free to consume it
                    if (!i_core_stall) begin
                        r_wb_valid  <= 1'b0;
                        r_mem_stall <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_mem_stall <= 1'b1;
                    end
                end
                default: begin
                    r_mem_req   <= 1'b0;
                    r_mem_stall <= 1'b0;
                    r_wb_valid  <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mem_stall          = r_mem_stall;
    assign o_mem_req            = r_mem_req;
    assign o_mem_we             = r_we;
    assign o_mem_addr           = {r_addr[DATA_W-1:2], 2'b00};
    assign o_mem_be             = r_be;
    assign o_mem_wdata          = r_wdata;
    assign o_wb_read_data       = r_wb_data;
    assign o_wb_read_data_valid = r_wb_valid;
    assign o_wb_load_rd         = r_wb_load_rd;
    assign o_dabort             = r_dabort;

endmodule

// File: doc/a25_mem_wb.md
# a25_mem_wb

Data-memory and load-return stage placed directly downstream of `a25_execute`. It accepts one data access per transaction from execute: address, write data, byte enables and load descriptor. It drives a single-outstanding req/ack memory port and stalls the core while the access is in flight. Load data is aligned and extended, then returned to execute on its write-back inputs (`i_wb_read_data`, `i_wb_read_data_valid`, `i_wb_load_rd`).

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles in REQ without `i_mem_ack` before abort; legal range 1..65535.
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  synchronous, active-low reset
- `i_core_stall`  in  1  core-wide stall; blocks acceptance and holds write-back
- `i_daddress`  in  32  byte address from execute
- `i_daddress_valid`  in  1  access request
- `i_write_enable`  in  1  1 = store, 0 = load
- `i_write_data`  in  32  store data, already lane-replicated by execute
- `i_byte_enable`  in  4  store byte lanes
- `i_exec_load_rd`  in  9  load descriptor: [3:0] dest reg, [4] user bank, [6:5] size (00 word, 01 half, 10 byte, 11 = word), [7] sign-extend, [8] passthrough flag
- `o_mem_stall`  out  1  access in flight; feeds execute `i_mem_stall`
- `o_mem_req`, `o_mem_we`  out  1 each  memory request / write
- `o_mem_addr`  out  32  `{addr[31:2], 2'b00}`
- `o_mem_be`  out  4  byte enables; 4'hF for loads
- `o_mem_wdata`  out  32  registered store data
- `i_mem_ack`  in  1  access complete
- `i_mem_err`  in  1  bus error, qualified by `i_mem_ack`
- `i_mem_rdata`  in  32  read data, valid with ack
- `o_wb_read_data`  out  32  aligned/extended load result
- `o_wb_read_data_valid`  out  1  result valid
- `o_wb_load_rd`  out  11  `{addr[1:0], exec_load_rd[8:0]}` of the returned load
- `o_dabort`  out  1  one-cycle pulse on error or timeout

## Operation
- FSM states: IDLE, REQ, WB.
- **IDLE**
  - Accept when `i_daddress_valid && !i_core_stall`.
  - On accept, register address, we, be, wdata and descriptor, then go to REQ.
- **REQ**
  - `o_mem_req = 1`, with all `o_mem_*` outputs stable until ack.
  - On `i_mem_ack && !i_mem_err`:
    - load: capture aligned data and go to WB;
    - store: go to IDLE.
  - On `i_mem_ack && i_mem_err`: pulse `o_dabort`, go to IDLE, no write-back.
  - Timeout: the counter clears on REQ entry and increments each REQ cycle without ack. If the count reaches TIMEOUT_CYCLES, take the error path. If ack arrives in the same cycle the count reaches TIMEOUT_CYCLES, the ack wins.
- **WB**
  - `o_wb_read_data_valid = 1`; data and `o_wb_load_rd` are held.
  - Exit to IDLE on the first cycle with `!i_core_stall`.
  - No acceptance in WB, so there is one bubble cycle before the next access.
- **Alignment** (sub-module), with `off = addr[1:0]`:
  - word: `rdata` rotated right by 8×off (ARM unaligned-load rotation);
  - half: lane `off[1]`, zero- or sign-extended from bit 15;
  - byte: lane `off`, extended from bit 7.
- `i_mem_ack` in IDLE or WB is ignored.

## Timing
- **Reset** (`!i_rst_n` at a clock edge):
  - state goes to IDLE and the counter clears;
  - every output is 0, including `o_mem_addr`, `o_mem_wdata` and `o_wb_*`;
  - an in-flight access is abandoned, and its later ack is ignored.
- `o_mem_stall` is a registered output, equal to (state == REQ) || (state == WB && i_core_stall).
- **Latency**
  - Acceptance at edge N puts `o_mem_req` high from N+1.
  - Ack sampled at edge M puts `o_mem_req` low after M.
  - For loads, `o_wb_read_data_valid` goes high from M+1 for at least one cycle.
  - Minimum load latency: 2 cycles accept→valid with zero-wait ack.
- `o_dabort` is high exactly one cycle, the cycle after the error/timeout edge.
- Simultaneous `i_core_stall` and ack in REQ: the ack is taken, and WB then holds valid for as long as the stall persists.

## Structure
- **Package `a25_mem_wb_pkg`**:
  - state enum `mem_wb_state_t`;
  - size localparams `LD_WORD`, `LD_HALF`, `LD_BYTE`;
  - descriptor field index constants (`LRD_REG_LSB`, `LRD_SIZE_LSB`, `LRD_SIGN`).
- **Sub-module `a25_load_align`**: combinational; inputs rdata, off, size, sign; output 32-bit result.
- **Harness `a25_mem_wb_random`**: drives wide inputs from `RandomNumberGenerator` instances, to keep I/O count down for bitstream builds.

## Test plan
- **Word load, zero-wait ack.** Addr 0x1000_0004 with rdata 0xDEADBEEF acked in the first REQ cycle → valid two cycles after accept, data 0xDEADBEEF, `o_wb_load_rd[10:9]` = 00.
- **Sign-extended byte load.** Addr 0x…0003, size byte, sign = 1, rdata 0x80112233 → 0xFFFFFF80. Same with sign = 0 → 0x00000080.
- **Unaligned word load.** Off 1, rdata 0x11223344 → 0x44112233. Half load off 2, sign = 1, rdata 0x9ABC0000 → 0xFFFF9ABC.
- **Store with 3 wait states.** be 4'b0100 → `o_mem_we` = 1, `o_mem_be` 0100, `o_mem_stall` high for 4 cycles, no wb valid.
- **Error and timeout.** Ack with err → `o_dabort` pulse, no valid. With TIMEOUT_CYCLES = 4 and no ack → abort after 4 REQ cycles, `o_mem_req` low. A late ack in IDLE is ignored.
- **Stall and reset.** Hold `i_core_stall` 5 cycles in WB → valid and data held 5 cycles. Assert `i_rst_n` = 0 mid-REQ → all outputs 0 next cycle, and the subsequent ack causes no write-back.
